// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs,
// blank patterns and digit count.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup; A-F fall through to blank
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver. New digit data is
// shadowed and committed only at frame boundaries so a frame never tears;
// each digit slot opens with a dead-time of all anodes off to kill ghosting.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  DEAD_END = CW'(DEAD_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp_q;
    logic [3:0]    dp_q;
    logic [15:0]   shadow_q;
    logic [3:0]    shadow_dp_q;
    logic          pending;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [NUM_DIGITS-1:0] zero_from;
    logic          blank_cur;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 2'd3);

    // Slot prescaler and digit index, scanning 0,1,2,3,0,...
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow/commit: loads park in the shadow until the frame edge; a load
    // landing on the edge itself goes straight to the displayed register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q      <= '0;
            dp_q        <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending     <= 1'b0;
        end else if (frame_end) begin
            pending <= 1'b0;
            if (load) begin
                disp_q <= digits_in;
                dp_q   <= dp_in;
            end else if (pending) begin
                disp_q <= shadow_q;
                dp_q   <= shadow_dp_q;
            end
        end else if (load) begin
            shadow_q    <= digits_in;
            shadow_dp_q <= dp_in;
            pending     <= 1'b1;
        end
    end

    // Frame marker lines up with the first cycle of the digit-0 slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_start <= 1'b0;
        else     frame_start <= frame_end;
    end

    // Current digit and leading-zero run: zero_from[k] means digits k..3 are all 0
    always_comb begin
        cur_digit    = disp_q[{idx, 2'b00} +: 4];
        zero_from    = '0;
        zero_from[3] = (disp_q[15:12] == 4'd0);
        zero_from[2] = zero_from[3] && (disp_q[11:8] == 4'd0);
        zero_from[1] = zero_from[2] && (disp_q[7:4]  == 4'd0);
        zero_from[0] = 1'b0;   // rightmost digit always shown
        blank_cur    = blank_lz && zero_from[idx];
    end

    seg7_decode u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Registered output stage: dead-time at slot start, then one anode low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (cnt < DEAD_END) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank_cur ? SEG_OFF : dec_seg;
            dp  <= ~dp_q[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle-count based reference model
// plus directed literal checks, followed by randomized loads.
module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Glyph table as listed for the display
    logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

    // Reference model: n = clock edges since reset release; slot position is
    // pure arithmetic on n. Expected outputs after each edge come from the
    // state seen before that edge.
    int unsigned n = 0;
    logic [15:0] m_disp = '0, m_sh = '0;
    logic [3:0]  m_dp = '0, m_shdp = '0;
    bit          m_pend = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1, e_fs = 1'b0;

    always @(posedge clk or posedge rst) begin : model_p
        int c, s;
        logic [3:0] d;
        if (rst) begin
            n <= 0; m_disp <= '0; m_sh <= '0; m_dp <= '0; m_shdp <= '0; m_pend <= 1'b0;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
        end else begin
            c = int'(n % SD);
            s = int'((n / SD) % 4);
            d = 4'((m_disp >> (4 * s)) & 16'hF);
            if (c < DC) begin
                e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1;
            end else begin
                e_an <= ~(4'b0001 << s);
                if (d > 4'd9 || (blank_lz && s > 0 && (m_disp >> (4 * s)) == 16'd0))
                    e_seg <= 7'h7F;
                else
                    e_seg <= segt[d];
                e_dp <= ~m_dp[s];
            end
            e_fs <= (c == SD - 1 && s == 3);
            if (c == SD - 1 && s == 3) begin
                if (load) begin m_disp <= digits_in; m_dp <= dp_in; end
                else if (m_pend) begin m_disp <= m_sh; m_dp <= m_shdp; end
                m_pend <= 1'b0;
            end else if (load) begin
                m_sh <= digits_in; m_shdp <= dp_in; m_pend <= 1'b1;
            end
            n <= n + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            tot_cnt++;
            if ({an, seg, dp, frame_start} === {e_an, e_seg, e_dp, e_fs})
                pass_cnt++;
            else
                $display("FAIL cycle_cmp t=%0t an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
                         $time, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s got=%h expected=%h", nm, act, exp);
    endtask

    task automatic wait_an(input logic [3:0] t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (an === t) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic check_slot(input logic [3:0] a, input logic [6:0] s, input logic d, input string nm);
        bit ok;
        wait_an(a, ok);
        if (!ok) begin
            tot_cnt++;
            $display("FAIL %s timeout waiting an=%b (got %b)", nm, a, an);
        end else begin
            chk({nm, "_seg"}, {9'd0, seg}, {9'd0, s});
            chk({nm, "_dp"}, {15'd0, dp}, {15'd0, d});
        end
    endtask

    task automatic wait_fs(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tot_cnt++;
            $display("FAIL %s timeout waiting frame_start", nm);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        digits_in = d; dp_in = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [15:0] rv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_an",  {12'd0, an}, 16'h000F);
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_dp",  {15'd0, dp}, 16'h0001);
        chk("rst_fs",  {15'd0, frame_start}, 16'h0000);
        rst = 1'b0;

        // Idle scan shows zeros
        check_slot(4'b1110, 7'b1000000, 1'b1, "idle_d0");
        check_slot(4'b1101, 7'b1000000, 1'b1, "idle_d1");

        // 1234 with dp on digit 2
        do_load(16'h1234, 4'b0100);
        wait_fs("fs_1234");
        check_slot(4'b1110, 7'b0011001, 1'b1, "v1234_d0");
        check_slot(4'b1101, 7'b0110000, 1'b1, "v1234_d1");
        check_slot(4'b1011, 7'b0100100, 1'b0, "v1234_d2");
        check_slot(4'b0111, 7'b1111001, 1'b1, "v1234_d3");

        // Two loads in a frame, latest wins, with leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h1111, 4'b0000);
        do_load(16'h0042, 4'b0000);
        wait_fs("fs_0042");
        check_slot(4'b1110, 7'b0100100, 1'b1, "v0042_d0");
        check_slot(4'b1101, 7'b0011001, 1'b1, "v0042_d1");
        check_slot(4'b1011, 7'h7F,      1'b1, "v0042_d2");
        check_slot(4'b0111, 7'h7F,      1'b1, "v0042_d3");

        // All zeros with blanking: only digit 0 lit, anodes still scan
        do_load(16'h0000, 4'b0000);
        wait_fs("fs_0000");
        check_slot(4'b1110, 7'b1000000, 1'b1, "v0000_d0");
        check_slot(4'b1101, 7'h7F,      1'b1, "v0000_d1");
        check_slot(4'b1011, 7'h7F,      1'b1, "v0000_d2");
        check_slot(4'b0111, 7'h7F,      1'b1, "v0000_d3");

        // Load exactly on the boundary edge overrides a pending shadow
        blank_lz = 1'b0;
        do_load(16'h5678, 4'b0000);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (n % (4 * SD) == 4 * SD - 1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin tot_cnt++; $display("FAIL bnd_wait timeout"); end
        digits_in = 16'h0987; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_fs", {15'd0, frame_start}, 16'h0001);
        check_slot(4'b1110, 7'b1111000, 1'b1, "bnd_d0");
        check_slot(4'b0111, 7'b1000000, 1'b1, "bnd_d3");
        wait_fs("fs_bnd2");
        check_slot(4'b1110, 7'b1111000, 1'b1, "bnd_next_d0");

        // Non-BCD digit blanks
        do_load(16'h000A, 4'b0000);
        wait_fs("fs_A");
        check_slot(4'b1110, 7'h7F,      1'b1, "vA_d0");
        check_slot(4'b1101, 7'b1000000, 1'b1, "vA_d1");

        // Asynchronous reset mid-slot
        wait_an(4'b1101, ok);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an",  {12'd0, an}, 16'h000F);
        chk("async_seg", {9'd0, seg}, 16'h007F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_slot(4'b1110, 7'b1000000, 1'b1, "post_rst_d0");

        // Randomized loads and blanking, checked cycle by cycle by the model
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            blank_lz = 1'($urandom_range(0, 1));
            rv = '0;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 1) == 1) rv[j*4 +: 4] = 4'($urandom_range(0, 15));
            do_load(rv, 4'($urandom_range(0, 15)));
        end
        repeat (80) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
